// File: rtl/fifo_push_rr_arbiter.sv
// Round-robin arbiter sharing one fifo_v3 push port among NUM_REQ valid/ready producers.
// Forward path is combinational; only the arbitration state (FSM, priority, lock index) is registered.
module fifo_push_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOCK_BURST = 1,
  parameter int unsigned IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic                                fifo_full_i,
  output logic                                fifo_push_o,
  output logic [DATA_WIDTH-1:0]               fifo_data_o,
  output logic [IDX_WIDTH-1:0]                grant_idx_o,
  output logic                                locked_o
);

  localparam int unsigned SUM_WIDTH = IDX_WIDTH + 1;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   rr_q, rr_d;
  logic [IDX_WIDTH-1:0]   lock_idx_q, lock_idx_d;

  logic                   win_found;
  logic [IDX_WIDTH-1:0]   win_idx;
  logic [SUM_WIDTH-1:0]   cand_sum;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   xfer;

  // Index after i, wrapping by explicit compare so non-power-of-two counts work.
  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] i);
    return (i == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : i + IDX_WIDTH'(1);
  endfunction

  // Winner selection: locked owner only, else first valid starting from rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    if (state_q == LOCKED) begin
      if (req_valid_i[lock_idx_q]) begin
        win_found = 1'b1;
        win_idx   = lock_idx_q;
      end
    end else begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        cand_sum = {1'b0, rr_q} + SUM_WIDTH'(off);
        if (cand_sum >= SUM_WIDTH'(NUM_REQ)) begin
          cand_sum = cand_sum - SUM_WIDTH'(NUM_REQ);
        end
        cand = cand_sum[IDX_WIDTH-1:0];
        if (!win_found && req_valid_i[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  assign xfer = win_found & ~fifo_full_i & ~flush_i;

  // Forward path toward the FIFO; everything is zero unless a beat actually moves.
  always_comb begin
    req_ready_o          = '0;
    req_ready_o[win_idx] = xfer;
    fifo_push_o          = xfer;
    fifo_data_o          = xfer ? req_data_i[win_idx] : '0;
    grant_idx_o          = xfer ? win_idx : '0;
    locked_o             = (state_q == LOCKED);
  end

  // Next-state: flush wins over everything, transitions only happen on a transfer.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      state_d    = ARB;
      rr_d       = '0;
      lock_idx_d = '0;
    end else if (xfer) begin
      unique case (state_q)
        ARB: begin
          if ((LOCK_BURST != 0) && !req_last_i[win_idx]) begin
            state_d    = LOCKED;
            lock_idx_d = win_idx;
          end else begin
            rr_d = next_idx(win_idx);
          end
        end
        LOCKED: begin
          if (req_last_i[lock_idx_q]) begin
            state_d = ARB;
            rr_d    = next_idx(lock_idx_q);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_q       <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule
